// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one outstanding access, byte lanes, timeout abort
// Optional misaligned-access trap state is built when MISALIGN_TRAP_EN is defined.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] sdata,
  input  logic [4:0]  rd,
  output logic        req_ready,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;
`endif

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ldata_q, ldata_d;
  logic          bus_err_q, bus_err_d;

  logic [3:0]    lane_mask;
  logic [31:0]   lane_wdata;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;
  logic          in_req, in_wb;
  logic          mis_in;

  // Size comes from funct3[1:0]; 10 and 11 both select a word, so reserved codes act as W.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = sdata_q;
    rd_shift   = mem_rdata;
    rd_ext     = mem_rdata;
    if (f3_q[1:0] == 2'b00) begin
      lane_mask  = 4'b0001 << addr_q[1:0];
      lane_wdata = {4{sdata_q[7:0]}};
      rd_shift   = mem_rdata >> {addr_q[1:0], 3'b000};
      rd_ext     = {{24{~f3_q[2] & rd_shift[7]}}, rd_shift[7:0]};
    end else if (f3_q[1:0] == 2'b01) begin
      lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{sdata_q[15:0]}};
      rd_shift   = mem_rdata >> {addr_q[1], 4'b0000};
      rd_ext     = {{16{~f3_q[2] & rd_shift[15]}}, rd_shift[15:0]};
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign mis_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ldata_d   = ldata_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = funct3;
          addr_d  = addr;
          sdata_d = sdata;
          rd_d    = rd;
          cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
          state_d = mis_in ? S_TRAP : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        // An ack in the final allowed cycle still completes the access.
        if (mem_ack) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            ldata_d = rd_ext;
            state_d = S_WB;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ldata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ldata_q   <= ldata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign in_req    = (state_q == S_REQ);
  assign in_wb     = (state_q == S_WB);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = (in_req & we_q) ? lane_wdata : 32'h0;
  assign mem_wmask = (in_req & we_q) ? lane_mask : 4'b0000;
  assign reg_wr    = in_wb & (rd_q != 5'd0);
  assign waddr     = in_wb ? rd_q : 5'd0;
  assign wdata     = in_wb ? ldata_q : 32'h0;
  assign bus_err   = bus_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign  = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit (TIMEOUT_CYC=4)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata, mem_rdata;
  logic [4:0]  rd;
  logic        req_ready, busy, mem_req, mem_we, reg_wr, bus_err;
  logic [31:0] mem_addr, mem_wdata, wdata;
  logic [3:0]  mem_wmask;
  logic [4:0]  waddr;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .sdata(sdata), .rd(rd), .req_ready(req_ready), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .reg_wr(reg_wr),
    .waddr(waddr), .wdata(wdata),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns #1 into the first busy cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; sdata = sd; rd = r;
    chk("accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // Load acked in the first REQ cycle; checks address, write-back and return to IDLE.
  task automatic load_ack(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic exp_wr,
                          input logic [31:0] exp_data);
    issue(1'b0, f3, a, 32'h0, r);
    mem_ack = 1'b1; mem_rdata = rdata;
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_wb_busy"}, busy, 1);
    chk({tag, "_reg_wr"}, reg_wr, exp_wr);
    if (exp_wr) begin
      chk({tag, "_waddr"}, waddr, r);
      chk({tag, "_wdata"}, wdata, exp_data);
    end
    tick();
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_reg_wr_off"}, reg_wr, 0);
  endtask

  // Store acked after one wait cycle; outputs must hold across the wait.
  task automatic store_ack(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_mask, input logic [31:0] exp_data);
    issue(1'b1, f3, a, sd, 5'd9);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) mem_ack = 1'b1;
      chk({tag, "_mem_we"}, mem_we, 1);
      chk({tag, "_mem_addr"}, mem_addr, exp_addr);
      chk({tag, "_mem_wmask"}, mem_wmask, exp_mask);
      chk({tag, "_mem_wdata"}, mem_wdata, exp_data);
      tick();
    end
    mem_ack = 1'b0;
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_no_reg_wr"}, reg_wr, 0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; sdata = 32'h0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    req_valid = 1'b1; mem_ack = 1'b1;
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_bus_err", bus_err, 0);
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ack_ignored", busy, 0);
    mem_ack = 1'b0;

    load_ack("lb",  3'b000, 32'h0000_0103, 5'd5,  32'h80FF_1234, 32'h0000_0100, 1'b1, 32'hFFFF_FF80);
    load_ack("lbu", 3'b100, 32'h0000_0042, 5'd6,  32'h1234_C856, 32'h0000_0040, 1'b1, 32'h0000_0034);
    load_ack("lhu", 3'b101, 32'h0000_0002, 5'd7,  32'h8765_4321, 32'h0000_0000, 1'b1, 32'h0000_8765);
    load_ack("lh",  3'b001, 32'h0000_0010, 5'd8,  32'h0000_9123, 32'h0000_0010, 1'b1, 32'hFFFF_9123);
    load_ack("lw_rd0", 3'b010, 32'h0000_0100, 5'd0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 32'h0);
    load_ack("lw_rsv", 3'b110, 32'h0000_0020, 5'd31, 32'hCAFE_F00D, 32'h0000_0020, 1'b1, 32'hCAFE_F00D);

    store_ack("sh", 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    store_ack("sb", 3'b000, 32'h0000_0005, 32'h1234_5677, 32'h0000_0004, 4'b0010, 32'h7777_7777);
    store_ack("sw_rsv", 3'b111, 32'h0000_0008, 32'h0BAD_F00D, 32'h0000_0008, 4'b1111, 32'h0BAD_F00D);

    // Timeout: no ack for four REQ cycles.
    issue(1'b0, 3'b001, 32'h0000_0000, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req", mem_req, 1);
      chk("to_no_err_yet", bus_err, 0);
      chk("to_no_reg_wr", reg_wr, 0);
      tick();
    end
    chk("to_bus_err", bus_err, 1);
    chk("to_mem_req_drop", mem_req, 0);
    chk("to_ready", req_ready, 1);
    chk("to_reg_wr", reg_wr, 0);
    tick();
    chk("to_bus_err_pulse", bus_err, 0);

    // Ack coinciding with the timeout cycle wins.
    issue(1'b0, 3'b100, 32'h0000_0001, 32'h0, 5'd10);
    for (int i = 0; i < 3; i++) tick();
    chk("late_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
    tick();
    mem_ack = 1'b0;
    chk("late_bus_err", bus_err, 0);
    chk("late_reg_wr", reg_wr, 1);
    chk("late_wdata", wdata, 32'h0000_009A);
    tick();
    chk("late_ready", req_ready, 1);

    // Reset in the second REQ cycle with ack aborts the load.
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd2);
    tick();
    chk("rreq_mem_req", mem_req, 1);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    chk("rreq_mem_req_off", mem_req, 0);
    chk("rreq_ready", req_ready, 1);
    chk("rreq_reg_wr", reg_wr, 0);
    rst = 1'b1; mem_ack = 1'b0;
    tick();
    chk("rreq_reg_wr_after", reg_wr, 0);
    chk("rreq_bus_err_after", bus_err, 0);

`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd4);
    chk("trap_misalign", misalign, 1);
    chk("trap_mem_req", mem_req, 0);
    chk("trap_reg_wr", reg_wr, 0);
    tick();
    chk("trap_misalign_off", misalign, 0);
    chk("trap_ready", req_ready, 1);
    chk("trap_mem_req_after", mem_req, 0);
`else
    load_ack("lw_mis", 3'b010, 32'h0000_0102, 5'd4, 32'h1122_3344, 32'h0000_0100, 1'b1, 32'h1122_3344);
    load_ack("lh_mis", 3'b001, 32'h0000_0003, 5'd11, 32'hF00D_1234, 32'h0000_0000, 1'b1, 32'hFFFF_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter TIMEOUT_CYC, default 64, SHALL set the maximum number of REQ-state cycles waiting for mem_ack before abort.
REQ-002: Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-003: clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004: rst  in  1  SHALL be the synchronous active-low reset.
REQ-005: req_valid  in  1  SHALL indicate that the execute stage presents a memory operation.
REQ-006: req_we  in  1  SHALL select the operation: 1 = store, 0 = load.
REQ-007: funct3  in  3  SHALL encode size and sign as per RV32I: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008: addr  in  32  SHALL carry the byte address (ALU result).
REQ-009: sdata  in  32  SHALL carry the store data (rs2 read data).
REQ-010: rd  in  5  SHALL carry the load destination register.
REQ-011: req_ready  out  1  SHALL be high only in IDLE.
REQ-012: busy  out  1  SHALL be high whenever the state is not IDLE; it is the pipeline stall.
REQ-013: mem_req, mem_we  out  1 each  SHALL form the memory request and its write strobe.
REQ-014: mem_addr  out  32  SHALL carry the word address {addr[31:2],2'b00}.
REQ-015: mem_wdata  out  32  SHALL carry the store data; mem_wmask  out  4  SHALL carry the byte enables.
REQ-016: mem_ack  in  1  SHALL signal completion; mem_rdata  in  32  SHALL be valid in the ack cycle.
REQ-017: reg_wr  out  1, waddr  out  5, wdata  out  32  SHALL form the register-file write port.
REQ-018: bus_err  out  1  SHALL pulse for one cycle when an access times out.

Function
REQ-019: The FSM SHALL have states IDLE, REQ, WB and TRAP (TRAP exists only under the macro).
REQ-020: In IDLE with req_valid=1, the unit SHALL latch we, funct3, addr, sdata and rd, then go to REQ at the next edge.
REQ-021: In REQ, mem_req SHALL be 1 and all mem_* outputs SHALL be held stable until mem_ack.
REQ-022: On mem_ack with a store, the unit SHALL go to IDLE; on mem_ack with a load, it SHALL register the extended data and go to WB.
REQ-023: WB SHALL last exactly one cycle, drive reg_wr=1 only if rd!=0, and return to IDLE.
REQ-024: Load latency SHALL be as follows: with accept at cycle 0 and ack in the first REQ cycle (cycle 1), reg_wr is high in cycle 2 and req_ready is high in cycle 3.
REQ-025: Store lanes SHALL be: B: mask 4'b0001<<addr[1:0], data {4{sdata[7:0]}}; H: mask 4'b0011<<(2*addr[1]), data {2{sdata[15:0]}}; W: mask 4'b1111, data sdata.
REQ-026: Load extraction SHALL shift mem_rdata right by 8*addr[1:0] (H uses addr[1] only; W no shift), then sign-extend for B/H or zero-extend for BU/HU.
REQ-027: Reserved funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-028: Stores SHALL take their size from funct3[1:0].
REQ-029: A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-030: When the counter reaches TIMEOUT_CYC-1 without ack, the unit SHALL pulse bus_err, drop mem_req, go to IDLE, and perform no register write.
REQ-031: mem_ack arriving in the same cycle as the timeout SHALL win, and the access completes normally.
REQ-032: mem_ack outside REQ SHALL be ignored.
REQ-033: req_valid outside IDLE SHALL be ignored; the upstream stage holds its request while busy=1.

Reset
REQ-034: With rst=0 at a rising edge, the next state SHALL be IDLE and the unit SHALL drive req_ready=1, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, reg_wr=0, waddr=0, wdata=0, bus_err=0, and a cleared counter.
REQ-035: Reset SHALL override simultaneous mem_ack or req_valid.
REQ-036: A reset asserted in REQ or WB SHALL abort the access with no reg_wr and no bus_err.

Configuration
REQ-037: With MISALIGN_TRAP_EN defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL enter TRAP for one cycle instead of REQ: no mem_req, no reg_wr, output misalign (out 1) =1 in TRAP, then IDLE.
REQ-038: Without MISALIGN_TRAP_EN, the misalign port and TRAP state SHALL not exist, and misaligned accesses SHALL be aligned down (H ignores addr[0], W ignores addr[1:0]).

Verification
REQ-039: LB from addr 0x103 with mem_rdata 0x80FF_1234 and ack in the first REQ cycle -> reg_wr in cycle 2, wdata 0xFFFFFF80.
REQ-040: SH of sdata 0x0000ABCD to addr 0x202 -> mem_addr 0x200, mem_wmask 4'b1100, mem_wdata 0xABCDABCD, no reg_wr.
REQ-041: LW with rd=0 -> WB state occurs, reg_wr stays 0.
REQ-042: Load with mem_ack never asserted and TIMEOUT_CYC=4 -> bus_err pulses after 4 REQ cycles, no reg_wr, req_ready returns to 1.
REQ-043: rst=0 in the second REQ cycle with mem_ack=1 -> IDLE next cycle, mem_req=0, reg_wr never asserted.
REQ-044: With MISALIGN_TRAP_EN, LW at 0x102 -> misalign=1 for one cycle and mem_req never asserted; without the macro -> mem_addr 0x100 and a normal load.
